// File: rtl/attention_row_engine.sv
// rtl/attention_row_engine.sv - single-query attention row: streamed K/V dot-product, weighted V accumulate, saturating output
module attention_row_engine #(
    parameter int M     = 166,
    parameter int N     = 44,
    parameter int DW    = 8,
    parameter int ACC_W = 48,
    localparam int AW   = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    input  logic [AW-1:0]     query_idx,
    input  logic [AW:0]       seq_len,
    input  logic [N*DW-1:0]   Q_in,
    input  logic [4:0]        score_shift,
    input  logic [5:0]        out_shift,
    input  logic              relu_en,
    output logic              kv_rd_en,
    output logic [AW-1:0]     kv_addr,
    input  logic [N*DW-1:0]   K_rd_data,
    input  logic [N*DW-1:0]   V_rd_data,
    output logic              out_valid,
    output logic [AW-1:0]     out_idx,
    output logic [N*DW-1:0]   out_data
);

    localparam int SW = 2 * DW + ((N > 1) ? $clog2(N) : 1);
    localparam logic [AW:0] M_CNT = (AW + 1)'(M);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, OUT} state_t;
    state_t state, state_nxt;

    logic [N*DW-1:0]          q_r;
    logic [AW-1:0]            qidx_r;
    logic [AW:0]              len_r;
    logic [4:0]               score_shift_r;
    logic [5:0]               out_shift_r;
    logic                     relu_en_r;
    logic                     out_phase;

    logic                     rd_pend;
    logic                     s_valid;
    logic signed [SW-1:0]     score_r;
    logic [N*DW-1:0]          v_r;
    logic signed [ACC_W-1:0]  acc     [N];
    logic signed [ACC_W-1:0]  acc_nxt [N];
    logic signed [ACC_W-1:0]  sh_r    [N];
    logic [DW-1:0]            sat_v   [N];

    logic [AW:0]              len_clamped;
    logic                     last_addr;
    logic signed [SW-1:0]     score_a;

    assign len_clamped = (seq_len > M_CNT) ? M_CNT : seq_len;
    assign last_addr   = (({1'b0, kv_addr} + (AW + 1)'(1)) == len_r);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len_clamped != '0) ? RUN : DRAIN1;
            RUN:     if (last_addr) state_nxt = DRAIN1;
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = OUT;
            OUT:     if (out_phase) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stage A: dot product of the latched query with the K row arriving this cycle
    always_comb begin
        logic signed [DW-1:0]   qe;
        logic signed [DW-1:0]   ke;
        logic signed [2*DW-1:0] prod_a;
        logic signed [SW-1:0]   dot;
        qe     = '0;
        ke     = '0;
        prod_a = '0;
        dot    = '0;
        for (int i = 0; i < N; i++) begin
            qe     = q_r[i*DW +: DW];
            ke     = K_rd_data[i*DW +: DW];
            prod_a = qe * ke;
            dot    = dot + SW'(prod_a);
        end
        score_a = dot >>> score_shift_r;
        if (relu_en_r && score_a[SW-1]) score_a = '0;
    end

    // Stage B: every lane accumulates score * V in parallel
    always_comb begin
        logic signed [DW-1:0]    vl;
        logic signed [SW+DW-1:0] prod_b;
        vl     = '0;
        prod_b = '0;
        for (int i = 0; i < N; i++) begin
            vl         = v_r[i*DW +: DW];
            prod_b     = score_r * vl;
            acc_nxt[i] = acc[i] + ACC_W'(prod_b);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (sh_r[i] > SAT_MAX)      sat_v[i] = SAT_MAX[DW-1:0];
            else if (sh_r[i] < SAT_MIN) sat_v[i] = SAT_MIN[DW-1:0];
            else                        sat_v[i] = sh_r[i][DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            kv_rd_en      <= 1'b0;
            kv_addr       <= '0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            out_data      <= '0;
            q_r           <= '0;
            qidx_r        <= '0;
            len_r         <= '0;
            score_shift_r <= '0;
            out_shift_r   <= '0;
            relu_en_r     <= 1'b0;
            out_phase     <= 1'b0;
            rd_pend       <= 1'b0;
            s_valid       <= 1'b0;
            score_r       <= '0;
            v_r           <= '0;
            for (int i = 0; i < N; i++) begin
                acc[i]  <= '0;
                sh_r[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            rd_pend   <= kv_rd_en;
            s_valid   <= rd_pend;
            if (rd_pend) begin
                score_r <= score_a;
                v_r     <= V_rd_data;
            end
            if (s_valid) begin
                for (int i = 0; i < N; i++) acc[i] <= acc_nxt[i];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        q_r           <= Q_in;
                        qidx_r        <= query_idx;
                        len_r         <= len_clamped;
                        score_shift_r <= score_shift;
                        out_shift_r   <= out_shift;
                        relu_en_r     <= relu_en;
                        kv_addr       <= '0;
                        kv_rd_en      <= (len_clamped != '0);
                        busy          <= 1'b1;
                        out_phase     <= 1'b0;
                        for (int i = 0; i < N; i++) acc[i] <= '0;
                    end
                end
                RUN: begin
                    if (last_addr) begin
                        kv_rd_en <= 1'b0;
                        kv_addr  <= '0;
                    end else begin
                        kv_addr  <= kv_addr + AW'(1);
                    end
                end
                // Shift is registered ahead of saturation to split the wide barrel shift from the compare
                OUT: begin
                    if (!out_phase) begin
                        for (int i = 0; i < N; i++) sh_r[i] <= acc[i] >>> out_shift_r;
                        out_phase <= 1'b1;
                    end else begin
                        for (int i = 0; i < N; i++) out_data[i*DW +: DW] <= sat_v[i];
                        out_idx   <= qidx_r;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        out_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
